// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space invaders game blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package space_invaders_pkg;

  // Visible screen area in pixels.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Coordinate the rocket parks itself at when not flying (off screen).
  localparam int PARKED = -20;

  // Formation and box size defaults.
  localparam int DEF_COLS     = 8;
  localparam int DEF_ROWS     = 4;
  localparam int DEF_ALIEN_W  = 24;
  localparam int DEF_ALIEN_H  = 16;
  localparam int DEF_PITCH_X  = 32;
  localparam int DEF_PITCH_Y  = 24;
  localparam int DEF_ROCKET_W = 2;
  localparam int DEF_ROCKET_H = 8;
  localparam int DEF_POINTS   = 10;
  localparam int DEF_SCORE_W  = 16;

  // Hit detector sequencing.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SCAN,
    ST_KILL,
    ST_WAIT
  } hit_state_t;

endpackage

// File: rtl/alien_hit_detector_row_overlap.sv
// row_overlap: rocket box vs. all COLS alien boxes of one formation row.
// Latency: combinational. Backpressure: none.
// Ports: rocket_x/rocket_y rocket top-left, grid_x formation left, row_y row top,
//        alive_row alive bits of the row, match per-column overlap (alive only).
module row_overlap
  import space_invaders_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ALIEN_W  = DEF_ALIEN_W,
  parameter int ALIEN_H  = DEF_ALIEN_H,
  parameter int PITCH_X  = DEF_PITCH_X,
  parameter int ROCKET_W = DEF_ROCKET_W,
  parameter int ROCKET_H = DEF_ROCKET_H
) (
  input  logic [9:0]      rocket_x,
  input  logic [8:0]      rocket_y,
  input  logic [9:0]      grid_x,
  input  logic [9:0]      row_y,
  input  logic [COLS-1:0] alive_row,
  output logic [COLS-1:0] match
);

  // Widened by one bit so boxes past the screen edge never wrap.
  logic [10:0] rx_l, rx_r;
  logic [9:0]  ry_t, ry_b, ay_b;
  logic        y_hit;

  assign rx_l  = {1'b0, rocket_x};
  assign rx_r  = rx_l + 11'(ROCKET_W);
  assign ry_t  = {1'b0, rocket_y};
  assign ry_b  = ry_t + 10'(ROCKET_H);
  assign ay_b  = row_y + 10'(ALIEN_H);
  // Vertical overlap is shared by every alien in the row.
  assign y_hit = (ry_t < ay_b) && (ry_b > row_y);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [10:0] ax;
    assign ax       = {1'b0, grid_x} + 11'(c * PITCH_X);
    assign match[c] = alive_row[c] && y_hit &&
                      (rx_l < ax + 11'(ALIEN_W)) && (rx_r > ax);
  end

endmodule

// File: rtl/alien_hit_detector.sv
// alien_hit_detector: owns the alien alive bitmap and score; scans one row per
// cycle against a rocket snapshot and kills the lowest matching alive alien.
// Latency: match in SCAN cycle t -> alive cleared and hit high at t+1; sweep = ROWS+1 cycles.
// Backpressure: none; playing low or new_wave abort the scan.
// Ports: playing/new_wave game control, flying/rocketX/rocketY from the rocket,
//        gridX/gridY formation origin, hit to rocket, alive/aliens_left/wave_cleared/score status.
module alien_hit_detector
  import space_invaders_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int ALIEN_W  = DEF_ALIEN_W,
  parameter int ALIEN_H  = DEF_ALIEN_H,
  parameter int PITCH_X  = DEF_PITCH_X,
  parameter int PITCH_Y  = DEF_PITCH_Y,
  parameter int ROCKET_W = DEF_ROCKET_W,
  parameter int ROCKET_H = DEF_ROCKET_H,
  parameter int POINTS   = DEF_POINTS,
  parameter int SCORE_W  = DEF_SCORE_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              playing,
  input  logic                              new_wave,
  input  logic                              flying,
  input  logic [9:0]                        rocketX,
  input  logic [8:0]                        rocketY,
  input  logic [9:0]                        gridX,
  input  logic [8:0]                        gridY,
  output logic                              hit,
  output logic [ROWS*COLS-1:0]              alive,
  output logic [$clog2(ROWS*COLS+1)-1:0]    aliens_left,
  output logic                              wave_cleared,
  output logic [SCORE_W-1:0]                score
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(N + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  // The rocket moves 2 px/cycle; a full sweep must be shorter than the
  // vertical window in which the boxes overlap, or a crossing could be missed.
  if (2 * (ROWS + 1) >= ALIEN_H + ROCKET_H) begin : g_cov_check
    $error("alien_hit_detector: sweep too slow for rocket speed");
  end

  hit_state_t       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [9:0]       snap_rx, snap_gx;
  logic [8:0]       snap_ry, snap_gy;
  logic [9:0]       row_y;
  logic [COLS-1:0]  row_alive, row_match;
  logic [CW-1:0]    kill_col;
  logic [IW-1:0]    kill_idx;
  logic             do_kill;

  assign row_y     = {1'b0, snap_gy} + 10'(int'(row_q) * PITCH_Y);
  assign row_alive = alive[int'(row_q)*COLS +: COLS];

  row_overlap #(
    .COLS     (COLS),
    .ALIEN_W  (ALIEN_W),
    .ALIEN_H  (ALIEN_H),
    .PITCH_X  (PITCH_X),
    .ROCKET_W (ROCKET_W),
    .ROCKET_H (ROCKET_H)
  ) u_row_overlap (
    .rocket_x  (snap_rx),
    .rocket_y  (snap_ry),
    .grid_x    (snap_gx),
    .row_y     (row_y),
    .alive_row (row_alive),
    .match     (row_match)
  );

  // Lowest matching column wins: scan downward so the last write is the lowest.
  always_comb begin
    kill_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (row_match[c]) kill_col = CW'(c);
    end
  end

  assign kill_idx = IW'(int'(row_q) * COLS + int'(kill_col));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    do_kill = 1'b0;
    case (state_q)
      ST_IDLE: if (playing && flying) state_d = ST_SNAP;
      ST_SNAP: begin
        state_d = ST_SCAN;
        row_d   = '0;
      end
      ST_SCAN: begin
        // A match in the cycle flying drops still counts.
        if (|row_match) begin
          state_d = ST_KILL;
          do_kill = 1'b1;
        end else if (!flying) begin
          state_d = ST_IDLE;
        end else if (int'(row_q) == ROWS - 1) begin
          state_d = ST_SNAP;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_KILL: state_d = ST_WAIT;
      // Hold until this rocket is gone so it cannot kill twice.
      ST_WAIT: if (!flying) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!playing || new_wave) begin
      state_d = ST_IDLE;
      do_kill = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      snap_rx <= '0;
      snap_ry <= '0;
      snap_gx <= '0;
      snap_gy <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (state_q == ST_SNAP) begin
        snap_rx <= rocketX;
        snap_ry <= rocketY;
        snap_gx <= gridX;
        snap_gy <= gridY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit          <= 1'b0;
      alive        <= '1;
      aliens_left  <= AW'(N);
      wave_cleared <= 1'b0;
      score        <= '0;
    end else begin
      hit <= do_kill;
      if (new_wave) begin
        alive        <= '1;
        aliens_left  <= AW'(N);
        wave_cleared <= 1'b0;
      end else if (do_kill) begin
        alive[kill_idx] <= 1'b0;
        aliens_left     <= aliens_left - 1'b1;
        wave_cleared    <= (aliens_left == AW'(1));
      end
      if (do_kill) begin
        if (score > SCORE_MAX - SCORE_W'(POINTS)) score <= SCORE_MAX;
        else                                      score <= score + SCORE_W'(POINTS);
      end
    end
  end

endmodule

// File: tb/tb_alien_hit_detector.sv
module tb_alien_hit_detector;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        playing = 1'b0;
  logic        new_wave = 1'b0;
  logic        flying = 1'b0;
  logic [9:0]  rocketX = '0;
  logic [8:0]  rocketY = '0;
  logic [9:0]  gridX = 10'd100;
  logic [8:0]  gridY = 9'd40;
  logic        hit;
  logic [N-1:0] alive;
  logic [5:0]  aliens_left;
  logic        wave_cleared;
  logic [15:0] score;

  alien_hit_detector dut (
    .clk          (clk),
    .reset        (reset),
    .playing      (playing),
    .new_wave     (new_wave),
    .flying       (flying),
    .rocketX      (rocketX),
    .rocketY      (rocketY),
    .gridX        (gridX),
    .gridY        (gridY),
    .hit          (hit),
    .alive        (alive),
    .aliens_left  (aliens_left),
    .wave_cleared (wave_cleared),
    .score        (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] score;
    int          lat;
  } exp_t;

  typedef struct {
    logic [9:0] rx;
    logic [8:0] ry;
    bit         kill;
    int         idx;
  } vec_t;

  exp_t         sbq[$];
  vec_t         vecs[10];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_alive = '1;
  int           exp_left = N;
  logic [15:0]  exp_score = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model a kill and queue what the DUT must show when it pulses hit.
  task automatic expect_kill(input int idx, input int lat);
    exp_t e;
    exp_alive[idx] = 1'b0;
    exp_left--;
    exp_score = exp_score + 16'd10;
    e.idx = idx; e.score = exp_score; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic on_hit(input string nm, input int t);
    exp_t e;
    if (sbq.size() == 0) begin
      check({nm, "_unexpected_hit"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      if (e.lat > 0) check({nm, "_latency"}, 64'(t), 64'(e.lat));
      check({nm, "_alive_bit"}, 64'(alive[e.idx]), 64'd0);
      check({nm, "_score"}, 64'(score), 64'(e.score));
    end
  endtask

  task automatic check_status(input string nm);
    check({nm, "_alive"}, 64'(alive), 64'(exp_alive));
    check({nm, "_left"}, 64'(aliens_left), 64'(exp_left));
    check({nm, "_cleared"}, 64'(wave_cleared), 64'(exp_left == 0));
    check({nm, "_score_now"}, 64'(score), 64'(exp_score));
    if (sbq.size() != 0) begin
      check({nm, "_missing_hit"}, 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  // Fire from IDLE and hold the rocket still for 20 cycles.
  task automatic shot(input string nm, input logic [9:0] x, input logic [8:0] y,
                      input bit kill, input int idx);
    int hits;
    if (kill) expect_kill(idx, 3 + idx / COLS);
    rocketX = x; rocketY = y; flying = 1'b1; hits = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (hit) begin
        hits++;
        on_hit(nm, t);
      end
    end
    flying = 1'b0;
    repeat (3) tick();
    check({nm, "_hits"}, 64'(hits), 64'(kill));
    check_status(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    // gridX=100, gridY=40: alien (r,c) x in [100+32c, +24), y in [40+24r, +16)
    vecs[0] = '{10'd140, 9'd50,  1'b1, 1};   // inside (0,1)
    vecs[1] = '{10'd158, 9'd50,  1'b0, 0};   // gap between col1 and col2
    vecs[2] = '{10'd140, 9'd50,  1'b0, 0};   // (0,1) already dead
    vecs[3] = '{10'd170, 9'd50,  1'b1, 2};   // (0,2)
    vecs[4] = '{10'd99,  9'd33,  1'b1, 0};   // (0,0) top-left corner touch
    vecs[5] = '{10'd98,  9'd50,  1'b0, 0};   // just left of col0
    vecs[6] = '{10'd124, 9'd50,  1'b0, 0};   // just right of col0
    vecs[7] = '{10'd123, 9'd79,  1'b1, 8};   // (1,0) bottom-right corner touch
    vecs[8] = '{10'd200, 9'd80,  1'b0, 0};   // between row1 and row2
    vecs[9] = '{10'd347, 9'd127, 1'b1, 31};  // (3,7) far corner

    reset = 1'b1;
    tick(); tick();
    check_status("reset");
    check("reset_hit", 64'(hit), 64'd0);
    reset = 1'b0;
    playing = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      shot($sformatf("vec%0d", i), vecs[i].rx, vecs[i].ry, vecs[i].kill, vecs[i].idx);

    // Descending rocket: row 3 is reached first, one kill only.
    expect_kill(25, 0);
    rocketX = 10'd140; rocketY = 9'd200; flying = 1'b1; hits = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (hit) begin
        hits++;
        on_hit("moving", k);
      end
      if (rocketY > 9'd2) rocketY = rocketY - 9'd2;
    end
    flying = 1'b0;
    repeat (3) tick();
    check("moving_hits", 64'(hits), 64'd1);
    check_status("moving");

    // flying drops in the row-0 SCAN cycle that matches (0,4): still kills.
    expect_kill(4, 0);
    rocketX = 10'd230; rocketY = 9'd50; flying = 1'b1;
    tick(); tick();
    flying = 1'b0;
    tick();
    check("drop_hit", 64'(hit), 64'd1);
    if (hit) on_hit("drop", 0);
    tick();
    check("drop_hit_one_cycle", 64'(hit), 64'd0);
    repeat (3) tick();
    check_status("drop");

    // new_wave in the SCAN cycle matching (0,3): repopulate, no kill.
    rocketX = 10'd200; rocketY = 9'd50; flying = 1'b1;
    tick(); tick();
    new_wave = 1'b1; flying = 1'b0;
    tick();
    new_wave = 1'b0;
    exp_alive = '1; exp_left = N;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      if (hit) hits++;
      tick();
    end
    check("newwave_hits", 64'(hits), 64'd0);
    check_status("newwave");

    // playing low: no scan, nothing changes.
    playing = 1'b0; rocketX = 10'd140; rocketY = 9'd50; flying = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (hit) hits++;
    end
    check("notplaying_hits", 64'(hits), 64'd0);
    flying = 1'b0; playing = 1'b1;
    repeat (3) tick();
    check_status("notplaying");

    // Asynchronous reset in the middle of a (missing) scan.
    rocketX = 10'd158; rocketY = 9'd50; flying = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    exp_alive = '1; exp_left = N; exp_score = '0;
    check_status("async_reset");
    check("async_reset_hit", 64'(hit), 64'd0);
    flying = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Clear the whole wave.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        shot($sformatf("all_r%0dc%0d", r, c), 10'(100 + 32 * c + 5), 9'(40 + 24 * r + 4),
             1'b1, r * COLS + c);
    check("all_score_320", 64'(score), 64'd320);
    check("all_wave_cleared", 64'(wave_cleared), 64'd1);
    shot("empty", 10'd140, 9'd50, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
